// File: rtl/simon_playback_if.sv
// Port bundle between simon_playback and its environment: start request, stack
// read side (EMPTY/DATA/POP) and the LED/status outputs.
interface simon_playback_if #(
  parameter int DATA_WIDTH = 2,
  parameter int DEPTH      = 16
);
  localparam int LED_W = 2 ** DATA_WIDTH;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                  start;
  logic                  stk_empty;
  logic [DATA_WIDTH-1:0] stk_data;
  logic                  stk_pop;
  logic [LED_W-1:0]      led;
  logic                  busy;
  logic                  done;
  logic [CNT_W-1:0]      count;
  logic                  tone;

  // master: the playback engine; slave: the stack / top-level that feeds it
  modport master (
    input  start, stk_empty, stk_data,
    output stk_pop, led, busy, done, count, tone
  );

  modport slave (
    output start, stk_empty, stk_data,
    input  stk_pop, led, busy, done, count, tone
  );
endinterface

// File: rtl/simon_playback.sv
// Simon playback engine: drains the sequence stack and shows each colour on a one-hot LED bus.
// Define SIMON_TONE_EN to add a per-colour square-wave tone on the tone output.
module simon_playback #(
  parameter int DATA_WIDTH = 2,
  parameter int DEPTH      = 16,
  parameter int ON_CYCLES  = 4,
  parameter int OFF_CYCLES = 2,
  parameter int TONE_DIV   = 8
) (
  input  logic              clk,
  input  logic              rst,
  simon_playback_if.master  bus
);

  localparam int LED_W   = 2 ** DATA_WIDTH;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int TMR_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  if (ON_CYCLES < 1 || OFF_CYCLES < 1 || TONE_DIV < 1) begin : g_cfg_check
    $error("simon_playback: ON_CYCLES, OFF_CYCLES and TONE_DIV must all be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHOW,
    S_GAP,
    S_FIN
  } state_t;

  state_t           state_reg;
  logic [LED_W-1:0] led_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [CNT_W-1:0] count_reg;
  logic [TMR_W-1:0] timer_reg;
  logic [LED_W-1:0] onehot_next;
  logic [CNT_W-1:0] count_next;
  logic             pop_now;

  // Decode the top-of-stack colour straight into the LED pattern it will light.
  for (genvar gi = 0; gi < LED_W; gi++) begin : g_decode
    assign onehot_next[gi] = (bus.stk_data == DATA_WIDTH'(gi));
  end

  assign count_next = (count_reg == CNT_W'(DEPTH)) ? count_reg : count_reg + 1'b1;

  // The pop strobe is the one output not registered: it must coincide with the
  // LOAD cycle in which the data is captured, and never fire on an empty stack.
  assign pop_now = (state_reg == S_LOAD) && !bus.stk_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      led_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      count_reg <= '0;
      timer_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            state_reg <= S_LOAD;
            busy_reg  <= 1'b1;
            count_reg <= '0;
          end
        end

        S_LOAD: begin
          if (bus.stk_empty) begin
            state_reg <= S_FIN;
            done_reg  <= 1'b1;
          end else begin
            state_reg <= S_SHOW;
            led_reg   <= onehot_next;
            count_reg <= count_next;
            timer_reg <= TMR_W'(ON_CYCLES - 1);
          end
        end

        S_SHOW: begin
          if (timer_reg == '0) begin
            state_reg <= S_GAP;
            led_reg   <= '0;
            timer_reg <= TMR_W'(OFF_CYCLES - 1);
          end else begin
            timer_reg <= timer_reg - 1'b1;
          end
        end

        // Return through LOAD so EMPTY is re-sampled after any pushes made meanwhile.
        S_GAP: begin
          if (timer_reg == '0) begin
            state_reg <= S_LOAD;
          end else begin
            timer_reg <= timer_reg - 1'b1;
          end
        end

        S_FIN: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end

        default: begin
          state_reg <= S_IDLE;
          led_reg   <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SIMON_TONE_EN
  localparam int TONE_W = $clog2(TONE_DIV * LED_W + 1);

  logic [DATA_WIDTH-1:0] tone_sym_reg;
  logic [TONE_W-1:0]     tone_cnt_reg;
  logic [TONE_W-1:0]     tone_period;
  logic                  tone_reg;

  // Higher colour codes get longer half-periods, giving each pad its own pitch.
  assign tone_period = TONE_W'(TONE_DIV) * (TONE_W'(tone_sym_reg) + 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tone_sym_reg <= '0;
      tone_cnt_reg <= '0;
      tone_reg     <= 1'b0;
    end else if (pop_now) begin
      tone_sym_reg <= bus.stk_data;
      tone_cnt_reg <= '0;
      tone_reg     <= 1'b0;
    end else if (state_reg == S_SHOW && timer_reg != '0) begin
      // timer_reg==0 is the last lit cycle, so that edge falls through to silence
      if (tone_cnt_reg == tone_period - 1'b1) begin
        tone_cnt_reg <= '0;
        tone_reg     <= ~tone_reg;
      end else begin
        tone_cnt_reg <= tone_cnt_reg + 1'b1;
      end
    end else begin
      tone_cnt_reg <= '0;
      tone_reg     <= 1'b0;
    end
  end

  assign bus.tone = tone_reg;
`else
  assign bus.tone = 1'b0;
`endif

  assign bus.stk_pop = pop_now;
  assign bus.led     = led_reg;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.count   = count_reg;

endmodule

// File: tb/tb_simon_playback.sv
// Bench for simon_playback: a queue-based stack feeds the DUT, and an expected
// per-cycle timeline is built from the playback rules and checked every cycle.
module tb_simon_playback;

  localparam int DEPTH = 16;
  localparam int ON_C  = 4;
  localparam int OFF_C = 2;

  typedef struct {
    logic       pop;
    logic [3:0] led;
    logic       busy;
    logic       done;
    logic [4:0] count;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;
  logic [1:0] stk[$];

  simon_playback_if #(.DATA_WIDTH(2), .DEPTH(DEPTH)) bus ();

  simon_playback #(
    .DATA_WIDTH(2), .DEPTH(DEPTH), .ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C), .TONE_DIV(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive_stack();
    bus.stk_empty = (stk.size() == 0);
    bus.stk_data  = (stk.size() != 0) ? stk[0] : 2'd0;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_pop"},   32'(bus.stk_pop), 32'd0);
    chk({tag, "_led"},   32'(bus.led),     32'd0);
    chk({tag, "_busy"},  32'(bus.busy),    32'd0);
    chk({tag, "_done"},  32'(bus.done),    32'd0);
    chk({tag, "_count"}, 32'(bus.count),   32'd0);
    chk({tag, "_tone"},  32'(bus.tone),    32'd0);
  endtask

  // Expected trace from the spec: per symbol one pop cycle, ON lit cycles and
  // OFF dark cycles; then an empty-check cycle, a DONE cycle, and idle.
  task automatic build_timeline(input logic [1:0] syms[$], output exp_t tl[$]);
    exp_t e;
    int   played;
    tl = {};
    for (int k = 0; k < syms.size(); k++) begin
      played = (k < DEPTH) ? k : DEPTH;
      e = '{pop: 1'b1, led: 4'd0, busy: 1'b1, done: 1'b0, count: 5'(played)};
      tl.push_back(e);
      played = (k + 1 < DEPTH) ? k + 1 : DEPTH;
      for (int c = 0; c < ON_C; c++) begin
        e = '{pop: 1'b0, led: 4'd1 << syms[k], busy: 1'b1, done: 1'b0, count: 5'(played)};
        tl.push_back(e);
      end
      for (int c = 0; c < OFF_C; c++) begin
        e = '{pop: 1'b0, led: 4'd0, busy: 1'b1, done: 1'b0, count: 5'(played)};
        tl.push_back(e);
      end
    end
    played = (syms.size() < DEPTH) ? syms.size() : DEPTH;
    e = '{pop: 1'b0, led: 4'd0, busy: 1'b1, done: 1'b0, count: 5'(played)};
    tl.push_back(e);
    e = '{pop: 1'b0, led: 4'd0, busy: 1'b1, done: 1'b1, count: 5'(played)};
    tl.push_back(e);
    e = '{pop: 1'b0, led: 4'd0, busy: 1'b0, done: 1'b0, count: 5'(played)};
    tl.push_back(e);
  endtask

  // Load the stack, pulse START, then compare every cycle. repulse raises START
  // again inside the first SHOW; abort_at >= 0 asserts rst at that cycle instead.
  task automatic run_play(input string tag, input logic [1:0] syms[$],
                          input bit repulse, input int abort_at);
    exp_t tl[$];
    logic pop_seen;
    build_timeline(syms, tl);
    stk = syms;
    drive_stack();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < tl.size(); i++) begin
      if (i == abort_at) begin
        rst = 1'b1;
        #1;
        chk_idle_zero({tag, "_rst"});
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      chk($sformatf("%s_c%0d_pop", tag, i),   32'(bus.stk_pop), 32'(tl[i].pop));
      chk($sformatf("%s_c%0d_led", tag, i),   32'(bus.led),     32'(tl[i].led));
      chk($sformatf("%s_c%0d_busy", tag, i),  32'(bus.busy),    32'(tl[i].busy));
      chk($sformatf("%s_c%0d_done", tag, i),  32'(bus.done),    32'(tl[i].done));
      chk($sformatf("%s_c%0d_count", tag, i), 32'(bus.count),   32'(tl[i].count));
      chk($sformatf("%s_c%0d_tone", tag, i),  32'(bus.tone),    32'd0);
      pop_seen  = bus.stk_pop;
      bus.start = (repulse && syms.size() != 0 && i == 2);
      @(posedge clk); #1;
      if (pop_seen && stk.size() != 0) begin
        void'(stk.pop_front());
        drive_stack();
      end
    end
    bus.start = 1'b0;
    chk({tag, "_stack_drained"}, 32'(stk.size()), 32'd0);
  endtask

  initial begin
    logic [1:0] syms[$];
    bus.start     = 1'b0;
    bus.stk_empty = 1'b1;
    bus.stk_data  = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    chk_idle_zero("post_reset");

    syms = '{2'd2, 2'd1, 2'd3};
    run_play("seq213", syms, 1'b0, -1);

    syms = '{};
    run_play("empty", syms, 1'b0, -1);

    syms = '{2'd2, 2'd1, 2'd3};
    run_play("repulse", syms, 1'b1, -1);

    syms = '{2'd0};
    run_play("single0", syms, 1'b0, -1);

    // rst lands in the second lit cycle of the second symbol
    syms = '{2'd1, 2'd3, 2'd0, 2'd2};
    run_play("midrst", syms, 1'b0, 1 + ON_C + OFF_C + 2);
    chk("midrst_left", 32'(stk.size()), 32'd2);
    syms = '{2'd0, 2'd2};
    run_play("resume", syms, 1'b0, -1);

    for (int r = 0; r < 6; r++) begin
      syms = '{};
      for (int k = 0; k < int'($urandom_range(1, 6)); k++)
        syms.push_back(2'($urandom_range(0, 3)));
      run_play($sformatf("rnd%0d", r), syms, 1'($urandom_range(0, 1)), -1);
    end

    // more symbols than DEPTH: count must stop at DEPTH
    syms = '{};
    for (int k = 0; k < DEPTH + 3; k++) syms.push_back(2'(k % 4));
    run_play("sat", syms, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
